// File: rtl/uart_rx.sv
// 8N1 serial receiver with a fractional-accumulator 16x oversampling tick and valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse.
module uart_rx #(
  parameter int OSC  = 50000000,
  parameter int BAUD = 115200,
  parameter int ACCW = 27
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [ACCW-1:0] StepIdle = ACCW'(16 * BAUD);
  localparam logic [ACCW-1:0] StepTick = ACCW'(16 * BAUD - OSC);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StBreak, StDeliver
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rxs_q;
  logic [ACCW-1:0] accu_q, accu_d;
  logic [3:0]      sub_q, sub_d;
  logic [2:0]      bitn_q, bitn_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            tick16;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
`endif

  // A non-negative accumulator means one 16x tick is due this cycle.
  assign tick16 = ~accu_q[ACCW-1];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= StIdle;
      accu_q       <= '0;
      sub_q        <= '0;
      bitn_q       <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rxd;
      rxs_q        <= rx_meta_q;
      state_q      <= state_d;
      accu_q       <= accu_d;
      sub_q        <= sub_d;
      bitn_q       <= bitn_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    accu_d      = tick16 ? accu_q + StepTick : accu_q + StepIdle;
    sub_d       = sub_q;
    bitn_d      = bitn_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q && !ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          sub_d   = '0;
          accu_d  = '0;
        end
      end
      StStart: begin
        if (tick16) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd7) begin
            if (rxs_q) begin
              state_d = StIdle;
            end else begin
              state_d = StData;
              sub_d   = '0;
              bitn_d  = '0;
            end
          end
        end
      end
      StData: begin
        if (tick16) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            shift_d = {rxs_q, shift_q[7:1]};
            if (bitn_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              bitn_d = bitn_q + 3'd1;
            end
          end
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (tick16) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            par_d   = rxs_q;
            state_d = StStop;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (tick16) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            if (rxs_q) begin
              state_d = StDeliver;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StBreak;
            end
          end
        end
      end
      StBreak: begin
        if (rxs_q) state_d = StIdle;
      end
      StDeliver: begin
        state_d = StIdle;
        if (!valid_q || ready) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        parity_err_d = par_q ^ (^shift_q);
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes are queued as frames are driven and
// checked on each valid&&ready handshake; pulse outputs are counted and checked per scenario.
module tb_uart_rx;

  localparam int Osc  = 50000000;
  localparam int Baud = 115200;
  localparam int Bit  = Osc / Baud;
`ifdef UART_RX_PARITY_EN
  localparam int StopTick = 8 + 16 * 8 + 16 + 15;
`else
  localparam int StopTick = 8 + 16 * 8 + 15;
`endif

  logic       clk = 1'b0;
  logic       reset_l;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vcyc = 0;

  uart_rx #(.OSC(Osc), .BAUD(Baud), .ACCW(27)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Monitor: counts pulses and pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (reset_l) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (parity_err) pe_cnt++;
      if (valid) vcyc++;
      if (valid && ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_byte: got %02h, required no byte", data);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          if (data !== e) begin
            miscompares++;
            $display("FAIL rx_data: got %02h, required %02h", data, e);
          end
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, Bit);
    for (int i = 0; i < 8; i++) hold(b[i], Bit);
`ifdef UART_RX_PARITY_EN
    hold(^b, Bit);
`endif
    hold(stop_bit, Bit);
  endtask

  // Clock cycles from the cycle START is entered (accumulator zeroed) to the stop-sample tick.
  function automatic int stop_tick_cycle();
    int a = 0;
    int n = 0;
    for (int c = 0; c < 100000; c++) begin
      if (a >= 0) begin
        if (n == StopTick) return c;
        n++;
        a += 16 * Baud - Osc;
      end else begin
        a += 16 * Baud;
      end
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset_l = 1'b0;
    rxd = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({data, valid, frame_err, overrun, parity_err} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%02h v=%b fe=%b ov=%b pe=%b, required all 0",
               data, valid, frame_err, overrun, parity_err);
    end
    reset_l = 1'b1;
    hold(1'b1, 20);
  endtask

  task automatic test_basic();
    int v0 = vcyc, f0 = fe_cnt, o0 = ov_cnt, p0 = pe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 100);
    vectors++;
    if (vcyc - v0 !== 1) begin
      miscompares++;
      $display("FAIL basic_valid_cycles: got %0d, required 1", vcyc - v0);
    end
    vectors++;
    if ({fe_cnt - f0, ov_cnt - o0, pe_cnt - p0} !== {32'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL basic_pulses: got fe=%0d ov=%0d pe=%0d, required 0 0 0",
               fe_cnt - f0, ov_cnt - o0, pe_cnt - p0);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_pending: got %0d undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_glitch();
    int v0 = vcyc;
    hold(1'b0, 100);
    hold(1'b1, 2 * Bit);
    vectors++;
    if (vcyc - v0 !== 0) begin
      miscompares++;
      $display("FAIL glitch_valid: got %0d valid cycles, required 0", vcyc - v0);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 100);
    vectors++;
    if (exp_q.size() != 0 || vcyc - v0 !== 1) begin
      miscompares++;
      $display("FAIL glitch_next: got pending=%0d vcyc=%0d, required 0 1", exp_q.size(), vcyc - v0);
    end
  endtask

  task automatic test_frame_err();
    int v0 = vcyc, f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    hold(1'b0, 20 * Bit);
    vectors++;
    if (fe_cnt - f0 !== 1 || vcyc - v0 !== 0) begin
      miscompares++;
      $display("FAIL frame_err_pulse: got fe=%0d vcyc=%0d, required 1 0", fe_cnt - f0, vcyc - v0);
    end
    hold(1'b1, Bit);
    vectors++;
    if (vcyc - v0 !== 0) begin
      miscompares++;
      $display("FAIL break_valid: got %0d valid cycles, required 0", vcyc - v0);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 100);
    vectors++;
    if (exp_q.size() != 0 || fe_cnt - f0 !== 1) begin
      miscompares++;
      $display("FAIL after_break: got pending=%0d fe=%0d, required 0 1", exp_q.size(), fe_cnt - f0);
    end
  endtask

  task automatic test_overrun();
    int o0 = ov_cnt;
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    hold(1'b1, 50);
    vectors++;
    if (valid !== 1'b1 || data !== 8'h11) begin
      miscompares++;
      $display("FAIL ovr_first: got v=%b data=%02h, required 1 11", valid, data);
    end
    send_frame(8'h22, 1'b1);
    hold(1'b1, 50);
    vectors++;
    if (ov_cnt - o0 !== 1 || valid !== 1'b1 || data !== 8'h11) begin
      miscompares++;
      $display("FAIL ovr_pulse: got ov=%0d v=%b data=%02h, required 1 1 11", ov_cnt - o0, valid, data);
    end
    ready = 1'b1;
    hold(1'b1, 5);
    ready = 1'b0;
    vectors++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ovr_drain: got v=%b pending=%0d, required 0 0", valid, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    int j = stop_tick_cycle();
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    hold(1'b1, 50);
    o0 = ov_cnt;
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (j + 4) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    hold(1'b1, 50);
    vectors++;
    if (ov_cnt - o0 !== 0 || valid !== 1'b1 || data !== 8'h22) begin
      miscompares++;
      $display("FAIL deliver_ready: got ov=%0d v=%b data=%02h, required 0 1 22",
               ov_cnt - o0, valid, data);
    end
    vectors++;
    if (exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL deliver_consumed: got pending=%0d, required 1", exp_q.size());
    end
    ready = 1'b1;
    hold(1'b1, 5);
  endtask

  task automatic test_reset_mid_frame();
    int v0 = vcyc;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (6 * Bit) @(posedge clk);
        #1 reset_l = 1'b0;
        #20;
        vectors++;
        if (data !== 8'h00 || valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_reset: got data=%02h v=%b ov=%b fe=%b, required 00 0 0 0",
                   data, valid, overrun, frame_err);
        end
      end
    join
    reset_l = 1'b1;
    hold(1'b1, 50);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    hold(1'b1, 100);
    vectors++;
    if (vcyc - v0 !== 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL after_reset: got vcyc=%0d pending=%0d, required 1 0", vcyc - v0, exp_q.size());
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0 = pe_cnt;
    logic [7:0] b = 8'h07;
    exp_q.push_back(b);
    hold(1'b0, Bit);
    for (int i = 0; i < 8; i++) hold(b[i], Bit);
    hold(1'b0, Bit);
    hold(1'b1, Bit);
    hold(1'b1, 100);
    vectors++;
    if (pe_cnt - p0 !== 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL parity_err: got pe=%0d pending=%0d, required 1 0", pe_cnt - p0, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
